reg_file_32x32: RTL and testbench

//  32-entry x 32-bit general register file with two registered read ports and one write port.

---
 rtl/reg_file_32x32.sv | 119 +++++++++++
 tb/tb_reg_file_32x32.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_32x32.sv
// 32 x 32 general register file, two registered read ports, one write port, write-first bypass.
// Latency: read data and RD_VALID appear one cycle after the READ strobe.
// Backpressure: none; every READ/WRITE strobe is accepted on the edge it is sampled.
module reg_file_32x32 #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int ZERO_REG   = 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  READ,
   input  logic                  WRITE,
   input  logic [ADDR_WIDTH-1:0] ADDR_R1,
   input  logic [ADDR_WIDTH-1:0] ADDR_R2,
   input  logic [ADDR_WIDTH-1:0] ADDR_W,
   input  logic [DATA_WIDTH-1:0] DATA_W,
   output logic [DATA_WIDTH-1:0] DATA_R1,
   output logic [DATA_WIDTH-1:0] DATA_R2,
   output logic                  RD_VALID
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DEPTH-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
   logic [DATA_WIDTH-1:0]            data_r1_q, data_r1_d;
   logic [DATA_WIDTH-1:0]            data_r2_q, data_r2_d;
   logic                             rd_valid_q, rd_valid_d;

   logic [DATA_WIDTH-1:0]            mux_r1, mux_r2;
   logic [DATA_WIDTH-1:0]            src_r1, src_r2;
   logic                             wr_to_zero;
   logic                             wr_en;
   logic                             byp_r1, byp_r2;

   mux32_32x1 #(
      .DATA_WIDTH (DATA_WIDTH),
      .SEL_WIDTH  (ADDR_WIDTH)
   ) u_mux_r1 (
      .data_in  (regs_q),
      .sel      (ADDR_R1),
      .data_out (mux_r1)
   );

   mux32_32x1 #(
      .DATA_WIDTH (DATA_WIDTH),
      .SEL_WIDTH  (ADDR_WIDTH)
   ) u_mux_r2 (
      .data_in  (regs_q),
      .sel      (ADDR_R2),
      .data_out (mux_r2)
   );

   // A dropped R0 write must neither update the array nor feed the bypass.
   always_comb begin
      wr_to_zero = (ZERO_REG != 0) && (ADDR_W == '0);
      wr_en      = WRITE && !wr_to_zero;
      byp_r1     = wr_en && (ADDR_R1 == ADDR_W);
      byp_r2     = wr_en && (ADDR_R2 == ADDR_W);
      src_r1     = byp_r1 ? DATA_W : mux_r1;
      src_r2     = byp_r2 ? DATA_W : mux_r2;
   end

   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[ADDR_W] = DATA_W;
      end
      if (ZERO_REG != 0) begin
         regs_d[0] = '0;
      end
   end

   always_comb begin
      data_r1_d  = data_r1_q;
      data_r2_d  = data_r2_q;
      rd_valid_d = READ;
      if (READ) begin
         data_r1_d = src_r1;
         data_r2_d = src_r2;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         regs_q     <= '0;
         data_r1_q  <= '0;
         data_r2_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         data_r1_q  <= data_r1_d;
         data_r2_q  <= data_r2_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign DATA_R1  = data_r1_q;
   assign DATA_R2  = data_r2_q;
   assign RD_VALID = rd_valid_q;

endmodule

// 32:1 word-wide read-select mux cell, one per read port.
// Latency: combinational.
// Backpressure: none.
module mux32_32x1 #(
   parameter int DATA_WIDTH = 32,
   parameter int SEL_WIDTH  = 5
) (
   input  logic [(1<<SEL_WIDTH)-1:0][DATA_WIDTH-1:0] data_in,
   input  logic [SEL_WIDTH-1:0]                      sel,
   output logic [DATA_WIDTH-1:0]                     data_out
);

   always_comb begin
      data_out = data_in[sel];
   end

endmodule

// File: tb/tb_reg_file_32x32.sv
// Directed bench for reg_file_32x32; runs a ZERO_REG=1 and a ZERO_REG=0 instance on shared stimulus.
module tb_reg_file_32x32;

   logic        clk;
   logic        rst;
   logic        read;
   logic        write;
   logic [4:0]  addr_r1;
   logic [4:0]  addr_r2;
   logic [4:0]  addr_w;
   logic [31:0] data_w;
   logic [31:0] data_r1, data_r2;
   logic        rd_valid;
   logic [31:0] z0_data_r1, z0_data_r2;
   logic        z0_rd_valid;

   int n_checks = 0;
   int n_fail   = 0;

   reg_file_32x32 #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1)) dut (
      .CLK      (clk),
      .RST      (rst),
      .READ     (read),
      .WRITE    (write),
      .ADDR_R1  (addr_r1),
      .ADDR_R2  (addr_r2),
      .ADDR_W   (addr_w),
      .DATA_W   (data_w),
      .DATA_R1  (data_r1),
      .DATA_R2  (data_r2),
      .RD_VALID (rd_valid)
   );

   reg_file_32x32 #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0)) dut_z0 (
      .CLK      (clk),
      .RST      (rst),
      .READ     (read),
      .WRITE    (write),
      .ADDR_R1  (addr_r1),
      .ADDR_R2  (addr_r2),
      .ADDR_W   (addr_w),
      .DATA_W   (data_w),
      .DATA_R1  (z0_data_r1),
      .DATA_R2  (z0_data_r2),
      .RD_VALID (z0_rd_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // All helpers enter and leave 1 time unit after a rising edge.
   task automatic do_write(input logic [4:0] a, input logic [31:0] d);
      write  = 1'b1;
      addr_w = a;
      data_w = d;
      @(posedge clk);
      #1;
      write  = 1'b0;
   endtask

   task automatic do_read(input logic [4:0] a1, input logic [4:0] a2);
      read    = 1'b1;
      addr_r1 = a1;
      addr_r2 = a2;
      @(posedge clk);
      #1;
      read    = 1'b0;
   endtask

   function automatic logic [31:0] sweep_val(input int a);
      return (a == 0) ? 32'h0 : (32'hA5A5_0000 + a);
   endfunction

   initial begin
      rst     = 1'b1;
      read    = 1'b0;
      write   = 1'b0;
      addr_r1 = '0;
      addr_r2 = '0;
      addr_w  = '0;
      data_w  = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_r1", data_r1, 32'h0);
      check("reset_r2", data_r2, 32'h0);
      check("reset_vld", {31'b0, rd_valid}, 32'h0);
      rst = 1'b0;

      // Reset pulse between edges must clear outputs immediately
      do_write(5'd2, 32'h5555_AAAA);
      do_read(5'd2, 5'd2);
      check("pre_rst_r1", data_r1, 32'h5555_AAAA);
      check("pre_rst_r2", data_r2, 32'h5555_AAAA);
      check("pre_rst_vld", {31'b0, rd_valid}, 32'h1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_r1", data_r1, 32'h0);
      check("async_rst_r2", data_r2, 32'h0);
      check("async_rst_vld", {31'b0, rd_valid}, 32'h0);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 32; i++) begin
         do_read(5'(i), 5'(31 - i));
         check("rst_sweep_r1", data_r1, 32'h0);
         check("rst_sweep_r2", data_r2, 32'h0);
      end

      // Write/read sweep
      for (int i = 1; i < 32; i++) begin
         do_write(5'(i), 32'hA5A5_0000 + 32'(i));
      end
      for (int i = 0; i < 32; i++) begin
         do_read(5'(i), 5'(31 - i));
         check("sweep_r1", data_r1, sweep_val(i));
         check("sweep_r2", data_r2, sweep_val(31 - i));
         check("sweep_vld", {31'b0, rd_valid}, 32'h1);
      end
      check("sweep_z0_r1", z0_data_r1, 32'hA5A5_001F);

      // R0 behaviour with and without ZERO_REG
      do_write(5'd0, 32'hDEAD_BEEF);
      do_read(5'd0, 5'd0);
      check("r0_zero_r1", data_r1, 32'h0);
      check("r0_zero_r2", data_r2, 32'h0);
      check("r0_plain_r1", z0_data_r1, 32'hDEAD_BEEF);
      check("r0_plain_r2", z0_data_r2, 32'hDEAD_BEEF);

      // Bypass, including the suppressed R0 case
      do_write(5'd5, 32'h1111_1111);
      write   = 1'b1;
      addr_w  = 5'd5;
      data_w  = 32'h2222_2222;
      do_read(5'd5, 5'd6);
      write   = 1'b0;
      check("byp_r1", data_r1, 32'h2222_2222);
      check("byp_r2", data_r2, 32'hA5A5_0006);
      do_read(5'd6, 5'd5);
      check("byp_stored", data_r2, 32'h2222_2222);
      write   = 1'b1;
      addr_w  = 5'd0;
      data_w  = 32'h1234_5678;
      do_read(5'd0, 5'd0);
      write   = 1'b0;
      check("byp_r0_zero", data_r1, 32'h0);
      check("byp_r0_plain", z0_data_r2, 32'h1234_5678);

      // Back-to-back: write in cycle n, read in cycle n+1
      do_write(5'd9, 32'h0BAD_F00D);
      do_read(5'd9, 5'd8);
      check("b2b_r1", data_r1, 32'h0BAD_F00D);
      check("b2b_r2", data_r2, 32'hA5A5_0008);

      // Hold while READ is low
      do_write(5'd3, 32'h0000_00FF);
      do_read(5'd3, 5'd3);
      check("hold_start", data_r1, 32'h0000_00FF);
      write  = 1'b1;
      addr_w = 5'd3;
      data_w = 32'h0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         check("hold_r1", data_r1, 32'h0000_00FF);
         check("hold_r2", data_r2, 32'h0000_00FF);
         check("hold_vld", {31'b0, rd_valid}, 32'h0);
      end
      write = 1'b0;
      do_read(5'd3, 5'd1);
      check("hold_after", data_r1, 32'h0);

      // Reset in the same cycle as a write
      write  = 1'b1;
      addr_w = 5'd7;
      data_w = 32'hCAFE_F00D;
      #2 rst = 1'b1;
      #1;
      check("midwr_vld", {31'b0, rd_valid}, 32'h0);
      @(posedge clk);
      #1;
      rst   = 1'b0;
      write = 1'b0;
      do_read(5'd7, 5'd5);
      check("midwr_r7", data_r1, 32'h0);
      check("midwr_r5", data_r2, 32'h0);
      check("midwr_vld_after", {31'b0, rd_valid}, 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
